cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Fetch/decode/execute control FSM for the 16-bit CPU core. Fetches a word over a
//  req/ack memory port, holds it in the instruction register feeding instr_decode,
//  consumes the decoded fields, and issues ALU-start, register-write and PC-update
//  strobes. One instruction is in flight at a time; there is no pipelining.
// PARAMETERS
//  WORD_SIZE  16  instruction/address/PC width (from parameters.v)
//  NIB_SIZE   4   opcode/register field width (from parameters.v)
//  BYTE_SIZE  8   bigval width (from parameters.v)
//  RESET_PC   0   PC value loaded on reset
// PORTS
//  clk        in   1          clock; all state updates on rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  mem_req    out  1          instruction fetch request
//  mem_addr   out  WORD_SIZE  fetch address (= pc)
//  mem_rdata  in   WORD_SIZE  fetched word; valid when mem_ack=1
//  mem_ack    in   1          fetch complete; sampled only while mem_req=1
//  instr      out  WORD_SIZE  instruction register, drives instr_decode.instr
//  opcode     in   NIB_SIZE   from instr_decode
//  isaluop    in   1          from instr_decode
//  bigval     in   BYTE_SIZE  from instr_decode
//  reg1_zero  in   1          register file: value of reg1 == 0
//  alu_start  out  1          one-cycle pulse starting the ALU operation
//  alu_done   in   1          ALU result valid
//  reg_we     out  1          one-cycle register-file write strobe (dest = reg1)
//  wb_sel     out  1          write-back source: 0 = ALU result, 1 = bigval zero-extended
//  pc         out  WORD_SIZE  program counter
//  halted     out  1          1 while in HALT
//  run        in   1          leave HALT
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous, valid mid-operation): state=FETCH, pc=RESET_PC,
//   instr=0, mem_req=0, alu_start=0, reg_we=0, wb_sel=0, halted=0. An outstanding fetch
//   is dropped; a mem_ack in the first cycle after release is ignored (mem_req=0).
//  mem_addr = pc combinationally. Outputs not named for a state are 0 in that state.
//  FETCH: mem_req=1; mem_req and mem_addr held stable until mem_ack. On a cycle with
//   mem_req & mem_ack: instr<=mem_rdata, pc<=pc+1 (mod 2^16), ->DECODE. Zero-wait ack
//   (ack in first req cycle) is legal; minimum fetch = 1 cycle.
//  DECODE: one settling cycle for instr_decode; dispatch on opcode:
//   isaluop (0-7)   -> ALU
//   8  LDI          -> WB with wb_sel=1
//   9  JMP          pc<={8'h00,bigval}; ->FETCH
//   10 BZ           if reg1_zero: pc<=pc+sext(bigval) (pc already incremented); ->FETCH
//   11 BNZ          as BZ with !reg1_zero
//   15 HALT         ->HALT
//   12-14 reserved  no effect; ->FETCH
//  ALU: alu_start=1 on first cycle only; wait for alu_done (done in the same cycle as
//   start is accepted); on alu_done ->WB with wb_sel=0. No timeout.
//  WB: reg_we=1 for exactly one cycle, wb_sel held; ->FETCH.
//  HALT: halted=1, no fetches; run=1 -> FETCH next cycle (halted drops with it).
//   run is ignored in every other state.
//  PC arithmetic wraps modulo 2^WORD_SIZE for increment and branch.
//  Latency (no memory/ALU wait): LDI 3 cycles, JMP/Bcc/NOP 2, ALU op 4 (1-cycle ALU).
// TESTING
//  1 Reset: rst_n low mid-ALU wait -> all outputs at reset values same cycle, pc=0;
//    after release, mem_req=1, mem_addr=0x0000.
//  2 Fetch stall: mem_ack low 3 cycles at addr 0 -> mem_req/mem_addr stable; ack with
//    rdata=0x8A5C -> instr=0x8A5C, pc=1, reg_we pulse with wb_sel=1 two cycles later.
//  3 ALU op 0x1123, alu_done delayed 2 cycles -> single alu_start pulse, reg_we pulse
//    with wb_sel=0 the cycle after alu_done, next fetch at pc+1.
//  4 Branch at pc=0x0010: BZ bigval=0xFE, reg1_zero=1 -> next fetch addr 0x000F;
//    reg1_zero=0 -> 0x0011; JMP bigval=0x40 -> 0x0040; BZ at 0xFFFF offset +1 -> 0x0001.
//  5 HALT 0xF000 -> halted=1, mem_req=0 for 10 cycles; run pulse -> fetch at pc+1.
//  6 Reserved opcode 0xC000 -> no reg_we/alu_start, fetch resumes at pc+1.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// Instruction-fetch bus between the sequencer (master) and instruction memory (slave).
// The master holds mem_req and mem_addr stable until the slave returns mem_ack
// together with the fetched word on mem_rdata.
interface cpu_sequencer_if #(
    parameter int WORD_SIZE = 16
);
    logic                 mem_req;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control FSM for the 16-bit CPU core.
// One instruction in flight: FETCH -> DECODE -> (ALU ->) (WB ->) FETCH, or HALT.
// The instruction register feeds an external decoder; the decoded fields come back
// as opcode/isaluop/bigval and are consumed in DECODE, one cycle after the fetch.
module cpu_sequencer #(
    parameter int                WORD_SIZE = 16,
    parameter int                NIB_SIZE  = 4,
    parameter int                BYTE_SIZE = 8,
    parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_sequencer_if.master      mem,
    output logic [WORD_SIZE-1:0] instr,
    input  logic [NIB_SIZE-1:0]  opcode,
    input  logic                 isaluop,
    input  logic [BYTE_SIZE-1:0] bigval,
    input  logic                 reg1_zero,
    output logic                 alu_start,
    input  logic                 alu_done,
    output logic                 reg_we,
    output logic                 wb_sel,
    output logic [WORD_SIZE-1:0] pc,
    output logic                 halted,
    input  logic                 run
);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_ALU,
        ST_WB,
        ST_HALT
    } state_t;

    localparam logic [NIB_SIZE-1:0] OP_LDI  = NIB_SIZE'(8);
    localparam logic [NIB_SIZE-1:0] OP_JMP  = NIB_SIZE'(9);
    localparam logic [NIB_SIZE-1:0] OP_BZ   = NIB_SIZE'(10);
    localparam logic [NIB_SIZE-1:0] OP_BNZ  = NIB_SIZE'(11);
    localparam logic [NIB_SIZE-1:0] OP_HALT = NIB_SIZE'(15);

    state_t               state_reg, state_next;
    logic [WORD_SIZE-1:0] pc_reg, pc_next;
    logic [WORD_SIZE-1:0] instr_reg, instr_next;
    logic                 wb_sel_reg, wb_sel_next;
    // Set once the ALU has been started, so alu_start fires only on the first ALU cycle.
    logic                 alu_wait_reg, alu_wait_next;
    // Cleared by reset so no request (and no ack) is honoured in the first cycle after release.
    logic                 fetch_armed_reg;

    logic                 fetch_req;
    logic                 alu_start_c;
    logic                 reg_we_c;
    logic                 wb_sel_c;
    logic                 halted_c;

    logic [WORD_SIZE-1:0] bigval_sext;
    logic [WORD_SIZE-1:0] bigval_zext;

    assign bigval_sext = {{(WORD_SIZE-BYTE_SIZE){bigval[BYTE_SIZE-1]}}, bigval};
    assign bigval_zext = {{(WORD_SIZE-BYTE_SIZE){1'b0}}, bigval};

    // State and datapath registers; reset drops any fetch or ALU wait in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_FETCH;
            pc_reg          <= RESET_PC;
            instr_reg       <= '0;
            wb_sel_reg      <= 1'b0;
            alu_wait_reg    <= 1'b0;
            fetch_armed_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            instr_reg       <= instr_next;
            wb_sel_reg      <= wb_sel_next;
            alu_wait_reg    <= alu_wait_next;
            fetch_armed_reg <= 1'b1;
        end
    end

    // Next-state, PC update and per-state strobes; every output defaults to 0.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        wb_sel_next   = wb_sel_reg;
        alu_wait_next = 1'b0;
        fetch_req     = 1'b0;
        alu_start_c   = 1'b0;
        reg_we_c      = 1'b0;
        wb_sel_c      = 1'b0;
        halted_c      = 1'b0;

        case (state_reg)
            ST_FETCH: begin
                fetch_req = fetch_armed_reg;
                if (fetch_armed_reg && mem.mem_ack) begin
                    instr_next = mem.mem_rdata;
                    pc_next    = pc_reg + WORD_SIZE'(1);
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (isaluop) begin
                    state_next = ST_ALU;
                end else begin
                    state_next = ST_FETCH;
                    case (opcode)
                        OP_LDI: begin
                            wb_sel_next = 1'b1;
                            state_next  = ST_WB;
                        end
                        OP_JMP:  pc_next = bigval_zext;
                        // pc already points past the branch, so the offset is relative to pc+1.
                        OP_BZ:   if (reg1_zero)  pc_next = pc_reg + bigval_sext;
                        OP_BNZ:  if (!reg1_zero) pc_next = pc_reg + bigval_sext;
                        OP_HALT: state_next = ST_HALT;
                        default: ;
                    endcase
                end
            end
            ST_ALU: begin
                alu_start_c = !alu_wait_reg;
                if (alu_done) begin
                    wb_sel_next = 1'b0;
                    state_next  = ST_WB;
                end else begin
                    alu_wait_next = 1'b1;
                end
            end
            ST_WB: begin
                reg_we_c   = 1'b1;
                wb_sel_c   = wb_sel_reg;
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                halted_c = 1'b1;
                if (run) state_next = ST_FETCH;
            end
            default: state_next = ST_FETCH;
        endcase
    end

    assign mem.mem_req  = fetch_req;
    assign mem.mem_addr = pc_reg;
    assign instr        = instr_reg;
    assign pc           = pc_reg;
    assign alu_start    = alu_start_c;
    assign reg_we       = reg_we_c;
    assign wb_sel       = wb_sel_c;
    assign halted       = halted_c;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: memory, decoder, register-zero flag and ALU are modelled here.
// Expected fetch addresses, instruction-register contents, ALU starts and write-backs
// are queued when a word is returned (or alu_done driven) and checked when they appear.
module tb_cpu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic        isaluop;
    logic [7:0]  bigval;
    logic        reg1_zero;
    logic        alu_start;
    logic        alu_done;
    logic        reg_we;
    logic        wb_sel;
    logic [15:0] pc;
    logic        halted;
    logic        run;
    logic        mem_req;
    logic [15:0] mem_addr;

    cpu_sequencer_if #(.WORD_SIZE(16)) mem_bus ();

    assign mem_bus.mem_ack   = mem_ack;
    assign mem_bus.mem_rdata = mem_rdata;
    assign mem_req           = mem_bus.mem_req;
    assign mem_addr          = mem_bus.mem_addr;

    // Decoder model: opcode in the top nibble, ALU ops 0-7, bigval in the low byte.
    // Register model: only r0 reads as zero.
    assign opcode    = instr[15:12];
    assign isaluop   = ~instr[15];
    assign bigval    = instr[7:0];
    assign reg1_zero = (instr[11:8] == 4'h0);

    cpu_sequencer #(
        .WORD_SIZE(16),
        .NIB_SIZE (4),
        .BYTE_SIZE(8),
        .RESET_PC (16'h0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem      (mem_bus),
        .instr    (instr),
        .opcode   (opcode),
        .isaluop  (isaluop),
        .bigval   (bigval),
        .reg1_zero(reg1_zero),
        .alu_start(alu_start),
        .alu_done (alu_done),
        .reg_we   (reg_we),
        .wb_sel   (wb_sel),
        .pc       (pc),
        .halted   (halted),
        .run      (run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] word;
        logic [15:0] pc_val;
    } instr_exp_t;

    typedef struct {
        int   cyc;
        logic sel;
    } wb_exp_t;

    logic [15:0] addr_q[$];
    instr_exp_t  instr_q[$];
    wb_exp_t     wb_q[$];
    int          alu_q[$];

    logic [15:0] prog      [logic [15:0]];
    int          stall_map [logic [15:0]];
    int          delay_map [logic [15:0]];

    int          n_tests;
    int          n_fail;
    int          cyc;
    bit          in_fetch;
    logic [15:0] fetch_addr;
    int          stall_left;
    int          alu_cnt;
    int          alu_delay_pending;
    bit          acked;
    logic [15:0] last_ack_addr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_wb(input int c, input logic s);
        wb_exp_t e;
        e.cyc = c;
        e.sel = s;
        wb_q.push_back(e);
    endtask

    // Return a word for the current request and queue everything it should cause.
    task automatic ack_fetch();
        logic [15:0] a;
        logic [15:0] w;
        logic [15:0] nxt;
        logic [15:0] sx;
        logic [7:0]  bv;
        logic [3:0]  op;
        instr_exp_t  ie;
        a = mem_addr;
        w = prog.exists(a) ? prog[a] : 16'hC000;
        if (addr_q.size() == 0) check_val("fetch_unexpected", mem_req, 0);
        else                    check_val("fetch_addr", a, addr_q.pop_front());
        mem_ack       = 1'b1;
        mem_rdata     = w;
        in_fetch      = 1'b0;
        acked         = 1'b1;
        last_ack_addr = a;
        $display("[TB] cycle %0d fetch addr=0x%04h word=0x%04h", cyc, a, w);

        ie.cyc    = cyc + 1;
        ie.word   = w;
        ie.pc_val = a + 16'h0001;
        instr_q.push_back(ie);

        op  = w[15:12];
        bv  = w[7:0];
        sx  = {{8{bv[7]}}, bv};
        nxt = a + 16'h0001;
        if (op < 4'd8) begin
            alu_q.push_back(cyc + 2);
            alu_delay_pending = delay_map.exists(a) ? delay_map[a] : 0;
        end else begin
            case (op)
                4'd8:  push_wb(cyc + 2, 1'b1);
                4'd9:  nxt = {8'h00, bv};
                4'd10: if (w[11:8] == 4'h0) nxt = a + 16'h0001 + sx;
                4'd11: if (w[11:8] != 4'h0) nxt = a + 16'h0001 + sx;
                default: ;
            endcase
        end
        addr_q.push_back(nxt);
    endtask

    // One clock: observe DUT outputs at the falling edge, then drive memory/ALU responses.
    task automatic step();
        instr_exp_t ie;
        wb_exp_t    we;
        @(negedge clk);
        cyc++;
        acked = 1'b0;

        if (instr_q.size() > 0 && instr_q[0].cyc == cyc) begin
            ie = instr_q.pop_front();
            check_val("instr_reg", instr, ie.word);
            check_val("pc_after_fetch", pc, ie.pc_val);
        end

        if (alu_q.size() > 0 && alu_q[0] < cyc) begin
            check_val("alu_start_missing", cyc, alu_q[0]);
            void'(alu_q.pop_front());
        end
        if (alu_start) begin
            if (alu_q.size() == 0) check_val("alu_start_unexpected", alu_start, 0);
            else                   check_val("alu_start_cycle", cyc, alu_q.pop_front());
        end

        if (wb_q.size() > 0 && wb_q[0].cyc < cyc) begin
            check_val("reg_we_missing", cyc, wb_q[0].cyc);
            void'(wb_q.pop_front());
        end
        if (reg_we) begin
            if (wb_q.size() == 0) begin
                check_val("reg_we_unexpected", reg_we, 0);
            end else begin
                we = wb_q.pop_front();
                check_val("reg_we_cycle", cyc, we.cyc);
                check_val("wb_sel", wb_sel, we.sel);
                $display("[TB] cycle %0d reg write wb_sel=%0b", cyc, wb_sel);
            end
        end

        if (alu_start) begin
            if (alu_delay_pending == 0) begin
                alu_done = 1'b1;
                push_wb(cyc + 1, 1'b0);
            end else begin
                alu_cnt  = alu_delay_pending;
                alu_done = 1'b0;
            end
        end else if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                alu_done = 1'b1;
                push_wb(cyc + 1, 1'b0);
            end else begin
                alu_done = 1'b0;
            end
        end else begin
            alu_done = 1'b0;
        end

        if (mem_req) begin
            if (!in_fetch) begin
                in_fetch   = 1'b1;
                fetch_addr = mem_addr;
                stall_left = stall_map.exists(mem_addr) ? stall_map[mem_addr] : 0;
            end else begin
                check_val("fetch_addr_stable", mem_addr, fetch_addr);
            end
            if (stall_left > 0) begin
                stall_left--;
                mem_ack = 1'b0;
            end else begin
                ack_fetch();
            end
        end else begin
            if (in_fetch) check_val("fetch_req_held", mem_req, 1);
            in_fetch = 1'b0;
            mem_ack  = 1'b0;
        end
    endtask

    task automatic run_until_ack(input logic [15:0] target, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (acked && last_ack_addr == target) found = 1'b1;
        end
        check_val("reached_fetch", {15'd0, found}, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_mem_req"},   mem_req,   0);
        check_val({tag, "_mem_addr"},  mem_addr,  16'h0000);
        check_val({tag, "_pc"},        pc,        16'h0000);
        check_val({tag, "_instr"},     instr,     16'h0000);
        check_val({tag, "_alu_start"}, alu_start, 0);
        check_val({tag, "_reg_we"},    reg_we,    0);
        check_val({tag, "_wb_sel"},    wb_sel,    0);
        check_val({tag, "_halted"},    halted,    0);
    endtask

    initial begin
        n_tests           = 0;
        n_fail            = 0;
        cyc               = 0;
        in_fetch          = 1'b0;
        fetch_addr        = 16'h0000;
        stall_left        = 0;
        alu_cnt           = 0;
        alu_delay_pending = 0;
        acked             = 1'b0;
        last_ack_addr     = 16'h0000;
        rst_n             = 1'b0;
        mem_ack           = 1'b0;
        mem_rdata         = 16'h0000;
        alu_done          = 1'b0;
        run               = 1'b0;

        // Program: LDI, ALU op, reserved, JMP, BZ taken backwards, JMP, BZ not taken,
        // JMP, HALT, then an ALU op that is interrupted by reset.
        prog[16'h0000] = 16'h8A5C;
        prog[16'h0001] = 16'h1123;
        prog[16'h0002] = 16'hC000;
        prog[16'h0003] = 16'h9010;
        prog[16'h0010] = 16'hA0FE;
        prog[16'h000F] = 16'h9020;
        prog[16'h0020] = 16'hA1FE;
        prog[16'h0021] = 16'h9040;
        prog[16'h0040] = 16'hF000;
        prog[16'h0041] = 16'h2345;
        stall_map[16'h0000] = 3;
        delay_map[16'h0001] = 2;
        delay_map[16'h0041] = 50;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        check_val("req_first_cycle_after_release", mem_req, 0);
        addr_q.push_back(16'h0000);

        run_until_ack(16'h0040, 200);

        step();
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("halt_halted", halted, 1);
            check_val("halt_no_fetch", mem_req, 0);
        end
        run = 1'b1;
        step();
        run = 1'b0;
        check_val("run_halted_drops", halted, 0);
        check_val("run_fetch_resumes", mem_req, 1);
        check_val("run_fetch_addr", mem_addr, 16'h0041);

        // Into the long ALU wait; run must be ignored here.
        step();
        step();
        run = 1'b1;
        step();
        step();
        run = 1'b0;
        check_val("alu_wait_not_halted", halted, 0);
        check_val("alu_wait_no_fetch", mem_req, 0);

        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        check_val("midreset_no_pending_wb", wb_q.size(), 0);
        addr_q.delete();
        instr_q.delete();
        wb_q.delete();
        alu_q.delete();
        alu_cnt    = 0;
        alu_done   = 1'b0;
        mem_ack    = 1'b0;
        in_fetch   = 1'b0;
        stall_left = 0;

        // After reset: BZ r0 -2 at 0 wraps to 0xFFFF, BZ r0 +1 there wraps to 0x0001.
        prog[16'h0000] = 16'hA0FE;
        prog[16'hFFFF] = 16'hA001;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("req_first_cycle_after_midreset", mem_req, 0);
        check_val("addr_after_midreset", mem_addr, 16'h0000);
        addr_q.push_back(16'h0000);

        run_until_ack(16'h0002, 100);
        repeat (4) step();
        check_val("wb_queue_drained", wb_q.size(), 0);
        check_val("alu_queue_drained", alu_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
